// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: card encoding, deck geometry
// and the dealer FSM state encoding.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam int DECK_SIZE   = 52;
  localparam int NUM_SLOTS   = 22;
  localparam int PLAYER_BASE = 11;
  localparam int RANKS       = 13;

  typedef enum logic [1:0] {
    FILL,
    SHUF,
    READY,
    DEAL
  } dealer_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, loads seed on reset and advances every cycle otherwise.
// Generic enough to serve as the RNG source for other game blocks.
module lfsr16 #(
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) state <= seed;
    else       state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
  end

endmodule

// File: rtl/card_dealer.sv
// Deck owner for the hand display: fills and Fisher-Yates shuffles a 52-card deck,
// then deals into dealer/player hands. CARD_DEALER_AUTO_RESHUFFLE_EN reshuffles on an empty-deck deal.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          HAND_MAX  = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shuffle_req,
  input  logic          new_round,
  input  logic          deal_req,
  input  logic          deal_to_player,
  output logic          busy,
  output logic          ready,
  output logic          deal_done,
  output logic          deal_err,
  output card_t         dealt_value,
  output logic [3:0]    dealer_card_count,
  output logic [3:0]    player_card_count,
  output card_t         card_values [0:NUM_SLOTS-1],
  output logic [5:0]    cards_remaining,
  output dealer_state_t dbg_state
);

  // Handshake: shuffle_req/new_round/deal_req are single-cycle pulses that are
  // accepted only while ready=1; anything seen while busy or dealing is dropped.

  dealer_state_t state;
  card_t         deck [0:DECK_SIZE-1];
  card_t         fill_rank;
  logic [5:0]    idx;
  logic [5:0]    deck_ptr;
  logic [15:0]   lfsr_state;
  logic [11:0]   j_prod;
  logic [5:0]    j;
  logic [3:0]    req_cnt;
  logic [4:0]    req_slot;
  logic          hand_full;
  logic          deck_empty;
  logic          tgt_player;
  logic [4:0]    tgt_slot;
  logic          pending;
  logic          unused_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  // Scaling a 6-bit random value by (i+1) and keeping the top bits lands j in 0..i.
  assign j_prod      = 12'(lfsr_state[5:0]) * 12'(idx + 6'd1);
  assign j           = j_prod[11:6];
  assign unused_bits = ^{lfsr_state[15:6], j_prod[5:0]};

  assign req_cnt    = deal_to_player ? player_card_count : dealer_card_count;
  assign req_slot   = deal_to_player ? 5'(PLAYER_BASE) + 5'(player_card_count)
                                     : 5'(dealer_card_count);
  assign hand_full  = (req_cnt == 4'(HAND_MAX));
  assign deck_empty = (deck_ptr == 6'(DECK_SIZE));

  assign cards_remaining = 6'(DECK_SIZE) - deck_ptr;
  assign busy            = (state == FILL) || (state == SHUF);
  assign ready           = (state == READY);
  assign dbg_state       = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FILL;
      idx               <= '0;
      fill_rank         <= 4'd1;
      deck_ptr          <= '0;
      dealer_card_count <= '0;
      player_card_count <= '0;
      dealt_value       <= '0;
      deal_done         <= 1'b0;
      deal_err          <= 1'b0;
      tgt_player        <= 1'b0;
      tgt_slot          <= '0;
      pending           <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) card_values[s] <= '0;
    end else begin
      deal_done <= 1'b0;
      deal_err  <= 1'b0;
      case (state)
        FILL: begin
          deck[idx] <= fill_rank;
          fill_rank <= (fill_rank == 4'(RANKS)) ? 4'd1 : fill_rank + 4'd1;
          if (idx == 6'(DECK_SIZE - 1)) state <= SHUF;
          else                          idx   <= idx + 6'd1;
        end
        SHUF: begin
          deck[idx] <= deck[j];
          deck[j]   <= deck[idx];
          if (idx == 6'd1) begin
            deck_ptr <= '0;
            state    <= pending ? DEAL : READY;
          end else begin
            idx <= idx - 6'd1;
          end
        end
        READY: begin
          if (new_round) begin
            dealer_card_count <= '0;
            player_card_count <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) card_values[s] <= '0;
          end else if (shuffle_req) begin
            state     <= FILL;
            idx       <= '0;
            fill_rank <= 4'd1;
          end else if (deal_req) begin
            if (hand_full) begin
              deal_err <= 1'b1;
            end else if (deck_empty) begin
`ifdef CARD_DEALER_AUTO_RESHUFFLE_EN
              pending    <= 1'b1;
              tgt_player <= deal_to_player;
              tgt_slot   <= req_slot;
              state      <= FILL;
              idx        <= '0;
              fill_rank  <= 4'd1;
`else
              deal_err <= 1'b1;
`endif
            end else begin
              tgt_player <= deal_to_player;
              tgt_slot   <= req_slot;
              state      <= DEAL;
            end
          end
        end
        DEAL: begin
          card_values[tgt_slot] <= deck[deck_ptr];
          dealt_value           <= deck[deck_ptr];
          if (tgt_player) player_card_count <= player_card_count + 4'd1;
          else            dealer_card_count <= dealer_card_count + 4'd1;
          deck_ptr  <= deck_ptr + 6'd1;
          deal_done <= 1'b1;
          pending   <= 1'b0;
          state     <= READY;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Writer side of the hand-display interface. Owns the 52-card deck and shuffles it with an LFSR-driven Fisher-Yates pass.
- On request, deals the next card into the dealer or player hand.
- Drives the per-slot card value array and the per-hand card counts that the layout and render logic consume.
- Sits between the blackjack game FSM (requests) and the card layout/render path (consumer).

Parameters:
- LFSR_SEED, 16'hACE1, nonzero reset seed of the shuffle LFSR.
- HAND_MAX, 11, maximum cards per hand.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- shuffle_req  in  1  refill and reshuffle the deck (pulse)
- new_round  in  1  clear both hands (pulse)
- deal_req  in  1  deal one card (pulse)
- deal_to_player  in  1  deal target: 1 = player, 0 = dealer; sampled with deal_req
- busy  out  1  fill/shuffle in progress
- ready  out  1  idle and accepting requests
- deal_done  out  1  one-cycle pulse, card written
- deal_err  out  1  one-cycle pulse, deal refused
- dealt_value  out  4  rank (1..13) of the last dealt card
- dealer_card_count  out  4  dealer cards held, 0..11
- player_card_count  out  4  player cards held, 0..11
- card_values  out  4 x [0:21]  slots 0-10 are dealer, slots 11-21 are player; 0 = empty
- cards_remaining  out  6  52 minus cards dealt since the last shuffle

Behaviour:
- Reset values: counts 0, all card_values 0, dealt_value 0, deal_done/deal_err 0, deck_ptr 0, LFSR = LFSR_SEED. The FSM enters FILL, so busy = 1 and ready = 0.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle in every state. Request timing therefore adds entropy.
- FSM states:
  - FILL: 52 cycles, deck[i] = (i mod 13) + 1, i = 0..51. Then go to SHUF with i = 51.
  - SHUF: 51 cycles, one swap per cycle of deck[i] and deck[j], i = 51 down to 1.
    - j = (lfsr[5:0] * (i+1)) >> 6, computed with a 6x6 multiply, so j is in 0..i.
    - After the i = 1 swap: deck_ptr = 0, go to READY.
  - READY: ready = 1, busy = 0. Request priority is new_round > shuffle_req > deal_req; lower-priority requests in the same cycle are dropped.
  - DEAL: one cycle, then return to READY.
- Total startup or reshuffle latency is 103 cycles from entry to FILL until ready.
- new_round in READY: both counts and all 22 values become 0 on the next edge. The deck is untouched and no pulse is emitted.
- shuffle_req in READY: go to FILL. Hands are untouched.
- deal_req in READY:
  - Target slot is dealer_card_count (dealer) or 11 + player_card_count (player).
  - If the target count equals HAND_MAX: deal_err on the next cycle, no state change.
  - If deck_ptr == 52: see Optional Feature.
  - Otherwise go to DEAL. On the exit edge of DEAL:
    - card_values[slot] = deck[deck_ptr]
    - dealt_value = deck[deck_ptr]
    - target count +1
    - deck_ptr +1
    - deal_done high for that one cycle
  - Request-to-done latency is 2 edges.
- Requests arriving outside READY are ignored, not queued.
- cards_remaining = 52 - deck_ptr, combinational from the register.
- Reset at any time, including mid-SHUF or mid-DEAL, restarts FILL from the full reset values. The result is deterministic: the deck order matches power-up if the request timing matches.

Optional Feature:
- Macro: CARD_DEALER_AUTO_RESHUFFLE_EN.
- Defined: a deal_req with deck_ptr == 52 latches the request and target, then runs FILL and SHUF (busy = 1). It then performs the pending deal directly, with deal_done 105 edges after the request. Hand-full checking still applies first.
- Undefined: deal_req with deck_ptr == 52 gives a deal_err pulse and no state change.

Decomposition:
- Package card_pkg:
  - card_t (logic [3:0])
  - DECK_SIZE = 52, NUM_SLOTS = 22, PLAYER_BASE = 11, RANKS = 13
  - dealer_state_t enum {FILL, SHUF, READY, DEAL}
- Sub-module lfsr16: clk, reset, seed, 16-bit state out. It is reusable for other games' RNG needs.

Test Plan:
- Reset release: busy = 1 for 103 cycles, then ready = 1 and cards_remaining = 52. Dealing 52 cards (new_round every 11) yields each rank 1..13 exactly 4 times.
- Three deal_req with deal_to_player = 1: three deal_done pulses, player_card_count = 3, card_values[11..13] nonzero and equal to the dealt_value sequence, card_values[14..21] = 0, cards_remaining = 49.
- 11 dealer deals, then a 12th: deal_err pulse, dealer_card_count stays 11, card_values[0..10] unchanged, cards_remaining = 41.
- new_round and deal_req in the same cycle: counts 0, all card_values 0, no deal_done, cards_remaining unchanged.
- Exhaust the deck, then deal_req:
  - Macro off: deal_err, cards_remaining = 0.
  - Macro on: busy for 103 cycles, deal_done, cards_remaining = 51.
- Reset asserted 20 cycles into SHUF and held 1 cycle, with identical request timing after: the deck order dealt equals the order from the first power-up.
